shift_reg_sequencer: RTL and testbench

//  Command sequencer for the 4-bit load/rotate/arith-shift register (controls ParallelLoadn, RotateRight, ASRight).

---
 rtl/shift_reg_sequencer.sv | 125 ++++++++++++
 tb/tb_shift_reg_sequencer.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/shift_reg_sequencer.sv
// Command sequencer for a 4-bit load/rotate/arith-shift register.
// Drives the register's control pins for N steps per accepted command, then pulses done with the result.
module shift_reg_sequencer #(
    parameter int CNT_W   = 4,
    parameter bit OPT_CNT = 1'b1
) (
    input  logic             Clock,
    input  logic             Reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [CNT_W-1:0] cmd_count,
    input  logic [3:0]       cmd_data,
    input  logic [3:0]       reg_q,
    output logic             ParallelLoadn,
    output logic             RotateRight,
    output logic             ASRight,
    output logic [3:0]       Data_IN,
    output logic             busy,
    output logic             done,
    output logic [3:0]       result
);

    // state | meaning
    // IDLE  | waiting for a command, register held by reloading reg_q
    // LOAD  | one cycle of parallel load with the latched data
    // SHIFT | rotate/shift until the step counter reaches 1
    // DONE  | one-cycle done pulse, register held, result = reg_q
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_DONE} state_t;

    localparam logic [1:0] OP_LOAD = 2'b00;
    localparam logic [1:0] OP_ROTR = 2'b01;
    localparam logic [1:0] OP_ROTL = 2'b10;
    localparam logic [1:0] OP_ASR  = 2'b11;

    state_t           state, state_nxt;
    logic [1:0]       op_q;
    logic [3:0]       data_q;
    logic [3:0]       result_q;
    logic [CNT_W-1:0] step_cnt;
    logic [CNT_W-1:0] eff_steps;
    logic             accept;

    assign cmd_ready = (state == S_IDLE) && !Reset;
    assign accept    = cmd_valid && cmd_ready;

    // Rotating by a multiple of 4 is a no-op and ASR saturates after 3 steps.
    always_comb begin
        eff_steps = cmd_count;
        if (OPT_CNT) begin
            if (cmd_op == OP_ASR)
                eff_steps = (cmd_count > CNT_W'(3)) ? CNT_W'(3) : cmd_count;
            else
                eff_steps = {{(CNT_W-2){1'b0}}, cmd_count[1:0]};
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state    <= S_IDLE;
            op_q     <= OP_LOAD;
            data_q   <= 4'b0;
            step_cnt <= '0;
            result_q <= 4'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                op_q     <= cmd_op;
                data_q   <= cmd_data;
                step_cnt <= eff_steps;
            end else if (state == S_SHIFT) begin
                step_cnt <= step_cnt - 1'b1;
            end
            if (state == S_DONE)
                result_q <= reg_q;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (cmd_op == OP_LOAD)
                        state_nxt = S_LOAD;
                    else if (eff_steps == '0)
                        state_nxt = S_DONE;
                    else
                        state_nxt = S_SHIFT;
                end
            end
            S_LOAD:  state_nxt = S_DONE;
            S_SHIFT: if (step_cnt == CNT_W'(1)) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        ParallelLoadn = 1'b0;
        RotateRight   = 1'b0;
        ASRight       = 1'b0;
        Data_IN       = reg_q;
        busy          = (state != S_IDLE);
        done          = (state == S_DONE);
        result        = (state == S_DONE) ? reg_q : result_q;
        case (state)
            S_LOAD: Data_IN = data_q;
            S_SHIFT: begin
                ParallelLoadn = 1'b1;
                case (op_q)
                    OP_ROTR: RotateRight = 1'b1;
                    OP_ROTL: RotateRight = 1'b0;
                    OP_ASR: begin
                        RotateRight = 1'b1;
                        ASRight     = 1'b1;
                    end
                    default: RotateRight = 1'b0;
                endcase
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_shift_reg_sequencer.sv
// Bench for shift_reg_sequencer: two instances (OPT_CNT=1 and OPT_CNT=0) share the command bus,
// each drives its own behavioural model of the 4-bit register.
module tb_shift_reg_sequencer;

    logic       Clock = 1'b0;
    logic       Reset;
    logic       cmd_valid;
    logic [1:0] cmd_op;
    logic [3:0] cmd_count;
    logic [3:0] cmd_data;

    logic       ready_o, pl_o, rr_o, asr_o, busy_o, done_o;
    logic [3:0] din_o, res_o, q_o;
    logic       ready_e, pl_e, rr_e, asr_e, busy_e, done_e;
    logic [3:0] din_e, res_e, q_e;

    int checks   = 0;
    int failures = 0;
    int hold_err = 0;

    always #5 Clock = ~Clock;

    shift_reg_sequencer #(.CNT_W(4), .OPT_CNT(1'b1)) u_opt (
        .Clock(Clock), .Reset(Reset), .cmd_valid(cmd_valid), .cmd_ready(ready_o),
        .cmd_op(cmd_op), .cmd_count(cmd_count), .cmd_data(cmd_data), .reg_q(q_o),
        .ParallelLoadn(pl_o), .RotateRight(rr_o), .ASRight(asr_o), .Data_IN(din_o),
        .busy(busy_o), .done(done_o), .result(res_o)
    );

    shift_reg_sequencer #(.CNT_W(4), .OPT_CNT(1'b0)) u_exact (
        .Clock(Clock), .Reset(Reset), .cmd_valid(cmd_valid), .cmd_ready(ready_e),
        .cmd_op(cmd_op), .cmd_count(cmd_count), .cmd_data(cmd_data), .reg_q(q_e),
        .ParallelLoadn(pl_e), .RotateRight(rr_e), .ASRight(asr_e), .Data_IN(din_e),
        .busy(busy_e), .done(done_e), .result(res_e)
    );

    // Register models; also flag any non-hold control while a sequencer is idle or done.
    always @(posedge Clock) begin
        if (Reset) begin
            q_o <= 4'b0;
            q_e <= 4'b0;
        end else begin
            if (!pl_o)      q_o <= din_o;
            else if (rr_o)  q_o <= {asr_o ? q_o[3] : q_o[0], q_o[3:1]};
            else            q_o <= {q_o[2:0], q_o[3]};
            if (!pl_e)      q_e <= din_e;
            else if (rr_e)  q_e <= {asr_e ? q_e[3] : q_e[0], q_e[3:1]};
            else            q_e <= {q_e[2:0], q_e[3]};
            if ((!busy_o || done_o) && (pl_o || din_o != q_o)) hold_err <= hold_err + 1;
            if ((!busy_e || done_e) && (pl_e || din_e != q_e)) hold_err <= hold_err + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    // Issue one command and follow both instances until idle; cycle 1 is the first after accept.
    task automatic do_cmd(input logic [1:0] op, input logic [3:0] cnt, input logic [3:0] dat,
                          output int dc_o, output int dc_e, output int sh_o, output int sh_e,
                          output logic [3:0] r_o, output logic [3:0] r_e,
                          output logic pl1, output logic [3:0] din1);
        dc_o = -1; dc_e = -1; sh_o = 0; sh_e = 0;
        r_o = 4'hx; r_e = 4'hx; pl1 = 1'bx; din1 = 4'hx;
        cmd_op = op; cmd_count = cnt; cmd_data = dat; cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            if (c == 1) begin
                pl1  = pl_o;
                din1 = din_o;
            end
            if (pl_o) sh_o++;
            if (pl_e) sh_e++;
            if (done_o) begin dc_o = c; r_o = res_o; end
            if (done_e) begin dc_e = c; r_e = res_e; end
            if (!busy_o && !busy_e) break;
            tick();
        end
    endtask

    int         dco, dce, sho, she;
    logic [3:0] ro, re, din1;
    logic       pl1;
    bit         saw_done;

    initial begin
        Reset = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_count = 4'd0; cmd_data = 4'd0;
        tick(); tick();
        check("rst_ready",  ready_o, 0);
        check("rst_busy",   busy_o, 0);
        check("rst_done",   done_o, 0);
        check("rst_result", res_o, 4'b0000);
        Reset = 1'b0;
        tick();
        check("post_rst_ready", ready_o, 1);

        // T1: LOAD 1001
        do_cmd(2'b00, 4'd0, 4'b1001, dco, dce, sho, she, ro, re, pl1, din1);
        check("t1_pl_cyc1",  pl1, 0);
        check("t1_din_cyc1", din1, 4'b1001);
        check("t1_done_cyc", dco, 2);
        check("t1_result",   ro, 4'b1001);
        check("t1_res_held", res_o, 4'b1001);

        // T2: ROTR 1 then ROTL 2
        do_cmd(2'b01, 4'd1, 4'd0, dco, dce, sho, she, ro, re, pl1, din1);
        check("t2r_done_cyc", dco, 2);
        check("t2r_shifts",   sho, 1);
        check("t2r_result",   ro, 4'b1100);
        do_cmd(2'b10, 4'd2, 4'd0, dco, dce, sho, she, ro, re, pl1, din1);
        check("t2l_done_cyc", dco, 3);
        check("t2l_shifts",   sho, 2);
        check("t2l_result",   ro, 4'b0011);
        check("t2l_result_e", re, 4'b0011);

        // T3: LOAD 1000, ASR 5 -> 3 steps with OPT_CNT, 5 exact
        do_cmd(2'b00, 4'd0, 4'b1000, dco, dce, sho, she, ro, re, pl1, din1);
        do_cmd(2'b11, 4'd5, 4'd0, dco, dce, sho, she, ro, re, pl1, din1);
        check("t3_shifts_opt", sho, 3);
        check("t3_done_opt",   dco, 4);
        check("t3_result_opt", ro, 4'b1111);
        check("t3_shifts_ex",  she, 5);
        check("t3_done_ex",    dce, 6);
        check("t3_result_ex",  re, 4'b1111);

        // T4: LOAD 0110, ROTL 4, ROTR 0, ROTR 6
        do_cmd(2'b00, 4'd0, 4'b0110, dco, dce, sho, she, ro, re, pl1, din1);
        do_cmd(2'b10, 4'd4, 4'd0, dco, dce, sho, she, ro, re, pl1, din1);
        check("t4a_done_opt",   dco, 1);
        check("t4a_result_opt", ro, 4'b0110);
        check("t4a_done_ex",    dce, 5);
        check("t4a_result_ex",  re, 4'b0110);
        do_cmd(2'b01, 4'd0, 4'd0, dco, dce, sho, she, ro, re, pl1, din1);
        check("t4b_done_opt", dco, 1);
        check("t4b_done_ex",  dce, 1);
        check("t4b_result",   ro, 4'b0110);
        do_cmd(2'b01, 4'd6, 4'd0, dco, dce, sho, she, ro, re, pl1, din1);
        check("t4c_done_opt",   dco, 3);
        check("t4c_result_opt", ro, 4'b1001);
        check("t4c_done_ex",    dce, 7);
        check("t4c_result_ex",  re, 4'b1001);

        // T5: ROTR 15, Reset in the 3rd SHIFT cycle
        saw_done = 1'b0;
        cmd_op = 2'b01; cmd_count = 4'd15; cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            if (done_e) saw_done = 1'b1;
            if (c < 3) tick();
        end
        check("t5_shift_ex", pl_e, 1);
        Reset = 1'b1;
        tick();
        if (done_e || done_o) saw_done = 1'b1;
        check("t5_no_done",    saw_done, 0);
        check("t5_busy",       busy_e, 0);
        check("t5_ready_rst",  ready_e, 0);
        check("t5_result",     res_e, 4'b0000);
        check("t5_reg_q",      q_e, 4'b0000);
        Reset = 1'b0;
        tick();
        check("t5_ready_after", ready_e, 1);
        check("t5_no_done_after", done_e, 0);

        // T6: hold while idle, then ignore cmd_valid while busy
        do_cmd(2'b00, 4'd0, 4'b0101, dco, dce, sho, she, ro, re, pl1, din1);
        repeat (10) tick();
        check("t6_idle_q",   q_o, 4'b0101);
        check("t6_idle_pl",  pl_o, 0);
        cmd_op = 2'b00; cmd_data = 4'b1010; cmd_valid = 1'b1;
        tick();
        cmd_op = 2'b01; cmd_count = 4'd1; cmd_data = 4'b0000;
        check("t6_busy_ready", ready_o, 0);
        tick();
        check("t6_done",   done_o, 1);
        check("t6_result", res_o, 4'b1010);
        tick();
        cmd_valid = 1'b0;
        repeat (3) tick();
        check("t6_no_extra_busy", busy_o, 0);
        check("t6_q_opt",  q_o, 4'b1010);
        check("t6_q_ex",   q_e, 4'b1010);
        check("t6_res_held", res_o, 4'b1010);

        check("hold_violations", hold_err, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
